// File: rtl/lsu_rmw.sv
// Load/store unit between MEM and a word-write-only data_mem: loads and SW take zero cycles,
// SB/SH take a two-cycle read-modify-write and stall the pipeline for the read cycle only.
module lsu_rmw #(
   parameter int ADDRESS_WIDTH = 8,
   parameter int DATA_WIDTH    = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  mem_req,
   input  logic                  mem_we,
   input  logic [2:0]            funct3,
   input  logic [DATA_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  stall,
   output logic                  misaligned,
   output logic                  dmem_we,
   output logic [DATA_WIDTH-1:0] dmem_a,
   output logic [DATA_WIDTH-1:0] dmem_wd,
   input  logic [DATA_WIDTH-1:0] dmem_rd
);

   typedef enum logic {IDLE = 1'b0, WRITE = 1'b1} state_t;

   state_t                   state;
   logic [DATA_WIDTH-1:0]    merge_q;
   logic [ADDRESS_WIDTH-1:0] idx_q;

   logic [ADDRESS_WIDTH-1:0] word_idx;
   logic                     illegal;
   logic                     is_half;
   logic                     is_word;
   logic                     align_bad;
   logic                     active;
   logic                     mis;
   logic                     ok;
   logic                     sub_store;
   logic [7:0]               byte_v;
   logic [15:0]              half_v;
   logic [DATA_WIDTH-1:0]    load_v;
   logic [DATA_WIDTH-1:0]    merged;

   // Upper address bits are deliberately dropped so accesses wrap.
   logic unused_addr_bits;
   assign unused_addr_bits = ^addr[DATA_WIDTH-1:ADDRESS_WIDTH+2];

   assign word_idx = addr[ADDRESS_WIDTH+1:2];
   assign is_half  = (funct3[1:0] == 2'b01);
   assign is_word  = (funct3[1:0] == 2'b10);
   assign byte_v   = dmem_rd[{addr[1:0], 3'b000} +: 8];
   assign half_v   = dmem_rd[{addr[1], 4'b0000} +: 16];

   always_comb begin
      illegal = 1'b1;
      case (funct3)
         3'b000, 3'b001, 3'b010: illegal = 1'b0;
         3'b100, 3'b101:         illegal = mem_we;
         default:                illegal = 1'b1;
      endcase
   end

   assign align_bad = (is_half & addr[0]) | (is_word & (addr[1:0] != 2'b00));
   // Reset dominates any request presented in the same cycle.
   assign active    = mem_req & ~rst & (state == IDLE);
   assign mis       = active & (illegal | align_bad);
   assign ok        = active & ~mis;
   assign sub_store = ok & mem_we & ~is_word;

   always_comb begin
      load_v = dmem_rd;
      case (funct3)
         3'b000:  load_v = {{(DATA_WIDTH-8){byte_v[7]}}, byte_v};
         3'b001:  load_v = {{(DATA_WIDTH-16){half_v[15]}}, half_v};
         3'b100:  load_v = {{(DATA_WIDTH-8){1'b0}}, byte_v};
         3'b101:  load_v = {{(DATA_WIDTH-16){1'b0}}, half_v};
         default: load_v = dmem_rd;
      endcase
   end

   always_comb begin
      merged = dmem_rd;
      if (is_half)
         merged[{addr[1], 4'b0000} +: 16] = wdata[15:0];
      else
         merged[{addr[1:0], 3'b000} +: 8] = wdata[7:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         merge_q <= '0;
         idx_q   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (sub_store) begin
                  merge_q <= merged;
                  idx_q   <= word_idx;
                  state   <= WRITE;
               end
            end
            WRITE:   state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign stall      = sub_store;
   assign misaligned = mis;
   assign rdata      = (ok & ~mem_we) ? load_v : '0;
   assign dmem_we    = ((state == WRITE) & ~rst) | (ok & mem_we & is_word);
   assign dmem_a     = (state == WRITE) ? {{(DATA_WIDTH-ADDRESS_WIDTH){1'b0}}, idx_q}
                                        : {{(DATA_WIDTH-ADDRESS_WIDTH){1'b0}}, word_idx};
   assign dmem_wd    = (state == WRITE) ? merge_q : wdata;

endmodule

// File: tb/tb_lsu_rmw.sv
// Bench for lsu_rmw: drives loads/stores against a behavioural data_mem and scoreboards results.
module tb_lsu_rmw;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_req;
   logic        mem_we;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        stall;
   logic        misaligned;
   logic        dmem_we;
   logic [31:0] dmem_a;
   logic [31:0] dmem_wd;
   logic [31:0] dmem_rd;

   logic [31:0] mem [256];

   typedef struct packed {
      logic [7:0]  idx;
      logic [31:0] data;
   } wr_t;

   logic [31:0] rd_q [$];
   wr_t         wr_q [$];

   int n_cmp  = 0;
   int n_fail = 0;

   lsu_rmw #(.ADDRESS_WIDTH(8), .DATA_WIDTH(32)) dut (
      .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .funct3(funct3),
      .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall), .misaligned(misaligned),
      .dmem_we(dmem_we), .dmem_a(dmem_a), .dmem_wd(dmem_wd), .dmem_rd(dmem_rd)
   );

   always #5 clk = ~clk;

   assign dmem_rd = mem[dmem_a[7:0]];
   always @(posedge clk) if (dmem_we) mem[dmem_a[7:0]] <= dmem_wd;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic idle();
      mem_req = 1'b0; mem_we = 1'b0; funct3 = 3'b000; addr = '0; wdata = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({rdata, stall, misaligned, dmem_we, dmem_a, dmem_wd} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got rdata=%h stall=%b mis=%b we=%b a=%h wd=%h, want all 0",
                  rdata, stall, misaligned, dmem_we, dmem_a, dmem_wd);
      end
   endtask

   task automatic do_sw(input logic [31:0] a, input logic [31:0] d);
      wr_t e;
      @(posedge clk); #1;
      mem_req = 1'b1; mem_we = 1'b1; funct3 = 3'b010; addr = a; wdata = d;
      wr_q.push_back('{idx: a[9:2], data: d});
      @(negedge clk);
      e = wr_q.pop_front();
      n_cmp++;
      if (dmem_we !== 1'b1 || stall !== 1'b0 || dmem_a !== {24'h0, e.idx} || dmem_wd !== e.data) begin
         n_fail++;
         $display("FAIL sw_cycle: got we=%b stall=%b a=%h wd=%h, want we=1 stall=0 a=%h wd=%h",
                  dmem_we, stall, dmem_a, dmem_wd, e.idx, e.data);
      end
      @(posedge clk); #1;
      idle();
      n_cmp++;
      if (mem[e.idx] !== e.data) begin
         n_fail++;
         $display("FAIL sw_commit: word %0d got %h want %h", e.idx, mem[e.idx], e.data);
      end
   endtask

   task automatic do_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] exp_v);
      logic [31:0] e;
      @(posedge clk); #1;
      mem_req = 1'b1; mem_we = 1'b0; funct3 = f3; addr = a; wdata = $urandom;
      rd_q.push_back(exp_v);
      @(negedge clk);
      e = rd_q.pop_front();
      n_cmp++;
      if (rdata !== e || stall !== 1'b0 || dmem_we !== 1'b0 || misaligned !== 1'b0) begin
         n_fail++;
         $display("FAIL load f3=%b a=%h: got rdata=%h stall=%b we=%b mis=%b, want rdata=%h stall=0 we=0 mis=0",
                  f3, a, rdata, stall, dmem_we, misaligned, e);
      end
      @(posedge clk); #1;
      idle();
   endtask

   // Drives one sub-word store; no idle cycle is inserted before it, so callers may chain them.
   task automatic sub_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                            input logic [31:0] exp_word);
      wr_t e;
      @(posedge clk); #1;
      mem_req = 1'b1; mem_we = 1'b1; funct3 = f3; addr = a; wdata = d;
      wr_q.push_back('{idx: a[9:2], data: exp_word});
      @(negedge clk);
      n_cmp++;
      if (stall !== 1'b1 || dmem_we !== 1'b0) begin
         n_fail++;
         $display("FAIL rmw_read a=%h: got stall=%b we=%b, want stall=1 we=0", a, stall, dmem_we);
      end
      @(posedge clk);
      @(negedge clk);
      e = wr_q.pop_front();
      n_cmp++;
      if (stall !== 1'b0 || dmem_we !== 1'b1 || dmem_a !== {24'h0, e.idx} || dmem_wd !== e.data) begin
         n_fail++;
         $display("FAIL rmw_write a=%h: got stall=%b we=%b a=%h wd=%h, want stall=0 we=1 a=%h wd=%h",
                  a, stall, dmem_we, dmem_a, dmem_wd, e.idx, e.data);
      end
   endtask

   task automatic finish_store(input logic [7:0] idx, input logic [31:0] exp_word);
      @(posedge clk); #1;
      idle();
      n_cmp++;
      if (mem[idx] !== exp_word) begin
         n_fail++;
         $display("FAIL rmw_commit: word %0d got %h want %h", idx, mem[idx], exp_word);
      end
   endtask

   task automatic test_loads();
      do_sw(32'h0C, 32'h8081_F2A4);
      do_load(3'b000, 32'h0D, 32'hFFFF_FFF2);
      do_load(3'b100, 32'h0F, 32'h0000_0080);
      do_load(3'b001, 32'h0E, 32'hFFFF_8081);
      do_load(3'b101, 32'h0C, 32'h0000_F2A4);
      do_load(3'b010, 32'h0C, 32'h8081_F2A4);
      do_load(3'b000, 32'h0C, 32'hFFFF_FFA4);
      do_load(3'b100, 32'h0E, 32'h0000_0081);
   endtask

   task automatic test_sw();
      do_sw(32'h10, 32'hDEAD_BEEF);
   endtask

   task automatic test_rmw();
      do_sw(32'h14, 32'h1122_3344);
      sub_store(3'b000, 32'h16, 32'h0000_00AB, 32'h11AB_3344);
      finish_store(8'd5, 32'h11AB_3344);
      sub_store(3'b001, 32'h14, 32'h0000_CAFE, 32'h11AB_CAFE);
      finish_store(8'd5, 32'h11AB_CAFE);
   endtask

   task automatic test_back_to_back();
      do_sw(32'h18, 32'h0000_0000);
      sub_store(3'b000, 32'h18, 32'hFFFF_FF11, 32'h0000_0011);
      sub_store(3'b000, 32'h1B, 32'h0000_0022, 32'h2200_0011);
      sub_store(3'b001, 32'h1A, 32'h0000_7733, 32'h7733_0011);
      finish_store(8'd6, 32'h7733_0011);
   endtask

   task automatic bad_access(input logic we, input logic [2:0] f3, input logic [31:0] a,
                             input logic [7:0] idx, input logic [31:0] keep);
      @(posedge clk); #1;
      mem_req = 1'b1; mem_we = we; funct3 = f3; addr = a; wdata = 32'hFFFF_FFFF;
      @(negedge clk);
      n_cmp++;
      if (misaligned !== 1'b1 || rdata !== 32'h0 || dmem_we !== 1'b0 || stall !== 1'b0) begin
         n_fail++;
         $display("FAIL misaligned a=%h f3=%b we=%b: got mis=%b rdata=%h dwe=%b stall=%b, want 1/0/0/0",
                  a, f3, we, misaligned, rdata, dmem_we, stall);
      end
      @(posedge clk); #1;
      idle();
      n_cmp++;
      if (mem[idx] !== keep) begin
         n_fail++;
         $display("FAIL misaligned_mem: word %0d got %h want %h", idx, mem[idx], keep);
      end
   endtask

   task automatic test_misaligned();
      do_sw(32'h00, 32'h0102_0304);
      do_sw(32'h04, 32'h0506_0708);
      bad_access(1'b0, 3'b010, 32'h02, 8'd0, 32'h0102_0304);
      bad_access(1'b1, 3'b001, 32'h05, 8'd1, 32'h0506_0708);
      bad_access(1'b0, 3'b011, 32'h04, 8'd1, 32'h0506_0708);
      bad_access(1'b1, 3'b100, 32'h04, 8'd1, 32'h0506_0708);
      bad_access(1'b1, 3'b010, 32'h07, 8'd1, 32'h0506_0708);
   endtask

   task automatic test_reset_mid_rmw();
      do_sw(32'h08, 32'hCAFE_F00D);
      @(posedge clk); #1;
      mem_req = 1'b1; mem_we = 1'b1; funct3 = 3'b000; addr = 32'h08; wdata = 32'h55;
      @(negedge clk);
      n_cmp++;
      if (stall !== 1'b1) begin
         n_fail++;
         $display("FAIL abort_read: got stall=%b want 1", stall);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (dmem_we !== 1'b0 || stall !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_write: got we=%b stall=%b want 0/0", dmem_we, stall);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      idle();
      @(negedge clk);
      n_cmp++;
      if (mem[2] !== 32'hCAFE_F00D || dmem_we !== 1'b0 || stall !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_after: word2=%h we=%b stall=%b, want cafef00d/0/0", mem[2], dmem_we, stall);
      end
      do_load(3'b010, 32'h08, 32'hCAFE_F00D);
      sub_store(3'b000, 32'h08, 32'h0000_0055, 32'hCAFE_F055);
      finish_store(8'd2, 32'hCAFE_F055);
   endtask

   task automatic test_wrap();
      do_sw(32'h0000_0400, 32'h1234_5678);
      sub_store(3'b000, 32'h0000_0401, 32'h0000_005A, 32'h1234_5A78);
      finish_store(8'd0, 32'h1234_5A78);
      do_load(3'b100, 32'hFFFF_FC01, 32'h0000_005A);
   endtask

   initial begin
      test_reset();
      test_loads();
      test_sw();
      test_rmw();
      test_back_to_back();
      test_misaligned();
      test_reset_mid_rmw();
      test_wrap();
      n_cmp++;
      if (rd_q.size() != 0 || wr_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d loads / %0d writes pending, want 0/0",
                  rd_q.size(), wr_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
